// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared widths and width sanity check for the systolic PE
package pe_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_BUS_WIDTH  = 32;

   // The accumulator must hold at least one full product without truncation.
   function automatic bit widths_ok(input int data_width, input int bus_width);
      return (data_width > 0) && (bus_width >= 2 * data_width);
   endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// rtl/pe_mac_unit.sv - combinational unsigned multiply and widened accumulate add
import pe_pkg::*;

module pe_mac_unit #(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int BUS_WIDTH  = DEFAULT_BUS_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] data_a,
   input  logic [DATA_WIDTH-1:0] data_b,
   input  logic [BUS_WIDTH-1:0]  accum,
   output logic [BUS_WIDTH-1:0]  sum,
   output logic                  carry
);

   logic [2*DATA_WIDTH-1:0] product;
   logic [BUS_WIDTH:0]      wide_sum;

   assign product  = data_a * data_b;
   // One extra bit on top of the accumulator captures the wrap-around carry.
   assign wide_sum = {1'b0, accum} + {{(BUS_WIDTH + 1 - 2 * DATA_WIDTH){1'b0}}, product};
   assign sum      = wide_sum[BUS_WIDTH-1:0];
   assign carry    = wide_sum[BUS_WIDTH];

endmodule

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - MAC processing element with east/south operand forwarding
import pe_pkg::*;

module systolic_pe #(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int BUS_WIDTH  = DEFAULT_BUS_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_operation_i,
   input  logic [DATA_WIDTH-1:0] data_A_i,
   input  logic [DATA_WIDTH-1:0] data_B_i,
   output logic [BUS_WIDTH-1:0]  accum_o,
   output logic [DATA_WIDTH-1:0] data_A_o,
   output logic [DATA_WIDTH-1:0] data_B_o,
   output logic                  ov_flag_o
);

   if (!widths_ok(DATA_WIDTH, BUS_WIDTH)) begin : g_bad_widths
      $error("systolic_pe: BUS_WIDTH must be >= 2*DATA_WIDTH");
   end

   logic [BUS_WIDTH-1:0]  accum_q;
   logic [DATA_WIDTH-1:0] data_a_q;
   logic [DATA_WIDTH-1:0] data_b_q;
   logic                  ov_q;
   logic [BUS_WIDTH-1:0]  mac_sum;
   logic                  mac_carry;

   pe_mac_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUS_WIDTH  (BUS_WIDTH)
   ) u_mac (
      .data_a (data_A_i),
      .data_b (data_B_i),
      .accum  (accum_q),
      .sum    (mac_sum),
      .carry  (mac_carry)
   );

   // Accumulator and overflow only move when enabled; overflow is sticky until reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         accum_q <= '0;
         ov_q    <= 1'b0;
      end else if (start_operation_i) begin
         accum_q <= mac_sum;
         if (mac_carry) begin
            ov_q <= 1'b1;
         end
      end
   end

   // Forwarding registers run every cycle to provide the systolic skew.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_a_q <= '0;
         data_b_q <= '0;
      end else begin
         data_a_q <= data_A_i;
         data_b_q <= data_B_i;
      end
   end

   assign accum_o   = accum_q;
   assign data_A_o  = data_a_q;
   assign data_B_o  = data_b_q;
   assign ov_flag_o = ov_q;

endmodule

// File: tb/tb_systolic_pe.sv
// tb/tb_systolic_pe.sv - self-checking bench for systolic_pe at 32- and 16-bit accumulators
module tb_systolic_pe;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;

   logic [31:0] acc32;
   logic [7:0]  ao32, bo32;
   logic        ov32;
   logic [15:0] acc16;
   logic [7:0]  ao16, bo16;
   logic        ov16;

   int passes = 0;
   int total  = 0;

   longint unsigned m_acc32, m_acc16;
   bit              m_ov32, m_ov16;
   logic [7:0]      m_ao, m_bo;

   always #5 clk = ~clk;

   systolic_pe dut32 (
      .clk_i             (clk),
      .rst_i             (rst),
      .start_operation_i (start),
      .data_A_i          (a),
      .data_B_i          (b),
      .accum_o           (acc32),
      .data_A_o          (ao32),
      .data_B_o          (bo32),
      .ov_flag_o         (ov32)
   );

   systolic_pe #(.DATA_WIDTH(8), .BUS_WIDTH(16)) dut16 (
      .clk_i             (clk),
      .rst_i             (rst),
      .start_operation_i (start),
      .data_A_i          (a),
      .data_B_i          (b),
      .accum_o           (acc16),
      .data_A_o          (ao16),
      .data_B_o          (bo16),
      .ov_flag_o         (ov16)
   );

   task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      check({tag, "_acc32"}, {32'd0, acc32}, m_acc32);
      check({tag, "_ov32"},  {63'd0, ov32},  {63'd0, m_ov32});
      check({tag, "_ao32"},  {56'd0, ao32},  {56'd0, m_ao});
      check({tag, "_bo32"},  {56'd0, bo32},  {56'd0, m_bo});
      check({tag, "_acc16"}, {48'd0, acc16}, m_acc16);
      check({tag, "_ov16"},  {63'd0, ov16},  {63'd0, m_ov16});
      check({tag, "_ao16"},  {56'd0, ao16},  {56'd0, m_ao});
      check({tag, "_bo16"},  {56'd0, bo16},  {56'd0, m_bo});
   endtask

   task automatic model_clear();
      m_acc32 = 0; m_acc16 = 0; m_ov32 = 0; m_ov16 = 0; m_ao = 0; m_bo = 0;
   endtask

   // Reference: plain arithmetic modulo 2^W with a sticky carry-out flag.
   task automatic model_edge(input logic [7:0] ta, input logic [7:0] tb, input logic ts);
      longint unsigned p, s;
      m_ao = ta;
      m_bo = tb;
      if (ts) begin
         p = longint'(ta) * longint'(tb);
         s = m_acc32 + p;
         if (s >= (64'd1 << 32)) m_ov32 = 1;
         m_acc32 = s % (64'd1 << 32);
         s = m_acc16 + p;
         if (s >= (64'd1 << 16)) m_ov16 = 1;
         m_acc16 = s % (64'd1 << 16);
      end
   endtask

   task automatic step(input logic [7:0] ta, input logic [7:0] tb, input logic ts, input string tag);
      @(negedge clk);
      a = ta; b = tb; start = ts;
      @(posedge clk);
      model_edge(ta, tb, ts);
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset pulse between edges with live operands applied.
   task automatic pulse_reset(input logic [7:0] ta, input logic [7:0] tb, input string tag);
      @(negedge clk);
      a = ta; b = tb; start = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      model_clear();
      check_all(tag);
      a = 8'd0; b = 8'd0; start = 1'b0;
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check_all("por");
      @(negedge clk);
      rst = 1'b0;

      // Build up nonzero state, then reset asynchronously and hold it across an edge.
      step(8'd9, 8'd9, 1'b1, "pre");
      @(negedge clk);
      a = 8'd200; b = 8'd100; start = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      model_clear();
      check_all("t1_async");
      @(posedge clk);
      #1;
      check_all("t1_held");
      @(negedge clk);
      a = 8'd0; b = 8'd0; start = 1'b0;
      rst = 1'b0;

      // MAC sequence with defaults.
      step(8'd7, 8'd3, 1'b1, "t2a");
      check("t2a_const", {32'd0, acc32}, 64'd21);
      step(8'd2, 8'd1, 1'b1, "t2b");
      check("t2b_const", {32'd0, acc32}, 64'd23);
      check("t2b_ao_const", {56'd0, ao32}, 64'd2);
      step(8'd0, 8'd0, 1'b1, "t2c");
      check("t2c_const", {32'd0, acc32}, 64'd23);

      // Hold with start low.
      for (int i = 0; i < 5; i++) step(8'd5, 8'd5, 1'b0, "t3");
      check("t3_acc_const", {32'd0, acc32}, 64'd23);
      check("t3_bo_const", {56'd0, bo32}, 64'd5);

      // Overflow on the 16-bit instance.
      pulse_reset(8'd1, 8'd1, "t4_rst");
      step(8'd255, 8'd255, 1'b1, "t4a");
      check("t4a_const", {48'd0, acc16}, 64'd65025);
      step(8'd255, 8'd255, 1'b1, "t4b");
      check("t4b_const", {48'd0, acc16}, 64'd64514);
      check("t4b_ov_const", {63'd0, ov16}, 64'd1);
      for (int i = 0; i < 4; i++) step(8'd0, 8'd0, 1'b0, "t4_hold");
      check("t4_ov_sticky", {63'd0, ov16}, 64'd1);

      // Reset mid-operation, then resume from zero.
      pulse_reset(8'd0, 8'd0, "t5_rst0");
      step(8'd7, 8'd3, 1'b1, "t5a");
      pulse_reset(8'd7, 8'd3, "t5_rst");
      check("t5_acc_zero", {32'd0, acc32}, 64'd0);
      step(8'd4, 8'd4, 1'b1, "t5b");
      check("t5b_const", {32'd0, acc32}, 64'd16);

      // Max operands on the default width.
      pulse_reset(8'd3, 8'd3, "t6_rst");
      for (int i = 0; i < 3; i++) step(8'd255, 8'd255, 1'b1, "t6");
      check("t6_const", {32'd0, acc32}, 64'd195075);
      check("t6_ov_const", {63'd0, ov32}, 64'd0);

      // Randomized traffic with occasional async resets and biased max operands.
      for (int i = 0; i < 300; i++) begin
         logic [7:0] ra, rb;
         ra = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
         if ($urandom_range(0, 39) == 0) pulse_reset(ra, rb, "rnd_rst");
         else step(ra, rb, 1'($urandom_range(0, 1)), "rnd");
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
